// File: rtl/axi4l_master_arbiter.sv
// Round-robin arbiter that gives REQ_N register-access requesters one shared AXI4-Lite master port.
// It runs a single outstanding transaction at a time and returns the result with a one-cycle ack.
module axi4l_master_arbiter #(
    parameter int REQ_N  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                          clk_axi,
    input  logic                          anrst_axi,
    input  logic [REQ_N-1:0]              req_valid,
    input  logic [REQ_N-1:0]              req_rnw,
    input  logic [REQ_N*ADDR_W-1:0]       req_addr,
    input  logic [REQ_N*DATA_W-1:0]       req_wdata,
    input  logic [REQ_N*(DATA_W/8)-1:0]   req_wstrb,
    output logic [REQ_N-1:0]              req_ack,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic [$clog2(REQ_N)-1:0]      grant_id,
    output logic                          busy,
    output logic [ADDR_W-1:0]             m_axi_awaddr,
    output logic [2:0]                    m_axi_awprot,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [DATA_W-1:0]             m_axi_wdata,
    output logic [DATA_W/8-1:0]           m_axi_wstrb,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic                          m_axi_bvalid,
    input  logic [1:0]                    m_axi_bresp,
    output logic                          m_axi_bready,
    output logic [ADDR_W-1:0]             m_axi_araddr,
    output logic [2:0]                    m_axi_arprot,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic                          m_axi_rvalid,
    input  logic [DATA_W-1:0]             m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    output logic                          m_axi_rready
);

    localparam int          STRB_W = DATA_W / 8;
    localparam int          IDW    = $clog2(REQ_N);
    localparam int unsigned N_U    = REQ_N;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } state_t;

    state_t              state_q, state_d;
    logic [IDW-1:0]      gid_q, gid_d;
    logic [IDW-1:0]      last_q, last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [REQ_N-1:0]    ack_q, ack_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          resp_q, resp_d;

    logic [REQ_N-1:0]    eligible;
    logic                pick_found;
    logic [IDW-1:0]      pick_idx;
    logic [IDW-1:0]      cand_idx;
    logic                aw_now;
    logic                w_now;

    // The requester just acked is masked so it cannot be re-granted in its own ack cycle.
    always_comb begin
        eligible   = req_valid & ~ack_q;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_idx   = '0;
        for (int unsigned off = 1; off <= N_U; off++) begin
            cand_idx = IDW'((32'(last_q) + off) % N_U);
            if (!pick_found && eligible[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gid_d     = gid_q;
        last_d    = last_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        ack_d     = '0;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        aw_now    = aw_done_q | m_axi_awready;
        w_now     = w_done_q | m_axi_wready;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gid_d     = pick_idx;
                    last_d    = pick_idx;
                    addr_d    = req_addr[pick_idx*ADDR_W +: ADDR_W];
                    wdata_d   = req_wdata[pick_idx*DATA_W +: DATA_W];
                    wstrb_d   = req_wstrb[pick_idx*STRB_W +: STRB_W];
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_rnw[pick_idx] ? RD_ADDR : WR_ADDR;
                end
            end
            WR_ADDR: begin
                aw_done_d = aw_now;
                w_done_d  = w_now;
                if (aw_now && w_now) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
                    state_d = IDLE;
                    ack_d   = {{(REQ_N-1){1'b0}}, 1'b1} << gid_q;
                    rdata_d = '0;
                    resp_d  = m_axi_bresp;
                end
            end
            RD_ADDR: begin
                if (m_axi_arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_axi_rvalid) begin
                    state_d = IDLE;
                    ack_d   = {{(REQ_N-1){1'b0}}, 1'b1} << gid_q;
                    rdata_d = m_axi_rdata;
                    resp_d  = m_axi_rresp;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_axi or negedge anrst_axi) begin
        if (!anrst_axi) begin
            state_q   <= IDLE;
            gid_q     <= '0;
            last_q    <= IDW'(REQ_N - 1);
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ack_q     <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            gid_q     <= gid_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    // All bus controls decode registered state only, so reset drops them immediately.
    assign m_axi_awvalid = (state_q == WR_ADDR) && !aw_done_q;
    assign m_axi_wvalid  = (state_q == WR_ADDR) && !w_done_q;
    assign m_axi_bready  = (state_q == WR_RESP);
    assign m_axi_arvalid = (state_q == RD_ADDR);
    assign m_axi_rready  = (state_q == RD_DATA);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_awprot  = '0;
    assign m_axi_arprot  = '0;
    assign req_ack       = ack_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;
    assign grant_id      = gid_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_axi4l_master_arbiter.sv
// Bench for axi4l_master_arbiter: directed scenarios plus randomized requesters and slave,
// checked every cycle against a transaction-level reference model.
module tb_axi4l_master_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic              clk_axi = 1'b0;
    logic              anrst_axi;
    logic [N-1:0]      req_valid, req_rnw, req_ack;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N*SW-1:0]   req_wstrb;
    logic [DW-1:0]     rsp_rdata;
    logic [1:0]        rsp_resp;
    logic [1:0]        grant_id;
    logic              busy;
    logic [AW-1:0]     m_axi_awaddr, m_axi_araddr;
    logic [2:0]        m_axi_awprot, m_axi_arprot;
    logic              m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [DW-1:0]     m_axi_wdata, m_axi_rdata;
    logic [SW-1:0]     m_axi_wstrb;
    logic              m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic [1:0]        m_axi_bresp, m_axi_rresp;
    logic              m_axi_rvalid, m_axi_rready;

    always #5 clk_axi = ~clk_axi;

    axi4l_master_arbiter #(.REQ_N(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_axi(clk_axi), .anrst_axi(anrst_axi),
        .req_valid(req_valid), .req_rnw(req_rnw), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ack(req_ack),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .grant_id(grant_id), .busy(busy),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rready(m_axi_rready)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    bit          auto_slave = 1'b0;
    bit          auto_req   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: one outstanding transaction tracked as a set of pending handshakes.
    bit            m_busy, m_rnw, m_resp_phase, m_need_aw, m_need_w;
    int            m_gid, m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [SW-1:0] m_wstrb;
    logic [N-1:0]  m_ack;
    logic [1:0]    m_resp;

    task automatic model_reset();
        m_busy = 0; m_rnw = 0; m_resp_phase = 0; m_need_aw = 0; m_need_w = 0;
        m_gid = 0; m_last = N - 1; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        m_ack = '0; m_rdata = '0; m_resp = '0;
    endtask

    task automatic model_step();
        logic [N-1:0] elig;
        logic [N-1:0] ack_next;
        bit           found;
        ack_next = '0;
        found    = 0;
        if (!m_busy) begin
            elig = req_valid & ~m_ack;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (!found && elig[c]) begin
                    found = 1; m_busy = 1; m_gid = c; m_last = c;
                    m_rnw = req_rnw[c];
                    m_addr = req_addr[c*AW +: AW];
                    m_wdata = req_wdata[c*DW +: DW];
                    m_wstrb = req_wstrb[c*SW +: SW];
                    m_resp_phase = 0;
                    m_need_aw = !m_rnw;
                    m_need_w = !m_rnw;
                end
            end
        end else if (!m_rnw) begin
            if (!m_resp_phase) begin
                if (m_axi_awready) m_need_aw = 0;
                if (m_axi_wready) m_need_w = 0;
                if (!m_need_aw && !m_need_w) m_resp_phase = 1;
            end else if (m_axi_bvalid) begin
                m_busy = 0; ack_next[m_gid] = 1'b1; m_rdata = '0; m_resp = m_axi_bresp;
            end
        end else begin
            if (!m_resp_phase) begin
                if (m_axi_arready) m_resp_phase = 1;
            end else if (m_axi_rvalid) begin
                m_busy = 0; ack_next[m_gid] = 1'b1; m_rdata = m_axi_rdata; m_resp = m_axi_rresp;
            end
        end
        m_ack = ack_next;
    endtask

    task automatic compare();
        bit e_aw, e_w, e_ar;
        e_aw = m_busy && !m_rnw && !m_resp_phase && m_need_aw;
        e_w  = m_busy && !m_rnw && !m_resp_phase && m_need_w;
        e_ar = m_busy && m_rnw && !m_resp_phase;
        chk("busy", busy, m_busy);
        chk("req_ack", req_ack, m_ack);
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_resp", rsp_resp, m_resp);
        chk("grant_id", grant_id, m_gid);
        chk("awvalid", m_axi_awvalid, e_aw);
        chk("wvalid", m_axi_wvalid, e_w);
        chk("bready", m_axi_bready, m_busy && !m_rnw && m_resp_phase);
        chk("arvalid", m_axi_arvalid, e_ar);
        chk("rready", m_axi_rready, m_busy && m_rnw && m_resp_phase);
        chk("prot", {m_axi_awprot, m_axi_arprot}, 6'b0);
        if (e_aw) chk("awaddr", m_axi_awaddr, m_addr);
        if (e_w) chk("wdata_wstrb", {m_axi_wdata, m_axi_wstrb}, {m_wdata, m_wstrb});
        if (e_ar) chk("araddr", m_axi_araddr, m_addr);
    endtask

    initial begin : compare_proc
        forever begin
            @(negedge clk_axi);
            if (!anrst_axi) model_reset();
            else model_step();
            compare();
        end
    end

    task automatic slave_rand();
        m_axi_awready = 1'($urandom_range(0, 1));
        m_axi_wready  = 1'($urandom_range(0, 1));
        m_axi_arready = 1'($urandom_range(0, 1));
        m_axi_bvalid  = m_axi_bready && ($urandom_range(0, 2) != 0);
        m_axi_bresp   = 2'($urandom_range(0, 3));
        m_axi_rvalid  = m_axi_rready && ($urandom_range(0, 2) != 0);
        m_axi_rdata   = $urandom;
        m_axi_rresp   = 2'($urandom_range(0, 3));
    endtask

    task automatic set_req(input int i, input bit rnw, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
        req_rnw[i] = rnw;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
        req_wstrb[i*SW +: SW] = s;
        req_valid[i] = 1'b1;
    endtask

    task automatic req_rand();
        for (int i = 0; i < N; i++) begin
            if (req_ack[i]) begin
                if ($urandom_range(0, 1) == 1)
                    set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
                else req_valid[i] = 1'b0;
            end else if (!req_valid[i]) begin
                if ($urandom_range(0, 3) == 0)
                    set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
            end else if ($urandom_range(0, 7) == 0) begin
                req_addr[i*AW +: AW] = $urandom;
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk_axi);
        #1;
        if (auto_slave) slave_rand();
        if (auto_req) req_rand();
    endtask

    task automatic slave_idle();
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = 0;
    endtask

    initial begin : stimulus
        int order[6];
        int n_acks;
        bit got;
        req_valid = '0; req_rnw = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        slave_idle();
        anrst_axi = 1'b1;
        #1 anrst_axi = 1'b0;
        repeat (3) cyc();
        chk("reset_busy", busy, 1'b0);
        chk("reset_ack", req_ack, 4'b0);
        chk("reset_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 5'b0);
        chk("reset_rsp", {rsp_rdata, rsp_resp, grant_id}, 36'h0);
        anrst_axi = 1'b1;

        // single zero-wait write from requester 0
        cyc();
        m_axi_awready = 1; m_axi_wready = 1; m_axi_bvalid = 1; m_axi_bresp = 0;
        set_req(0, 0, 32'h10, 32'hDEADBEEF, 4'hF);
        cyc();
        chk("wr_c1_valids", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
        chk("wr_c1_awaddr", m_axi_awaddr, 32'h10);
        chk("wr_c1_wdata", m_axi_wdata, 32'hDEADBEEF);
        cyc();
        chk("wr_c2_bready", m_axi_bready, 1'b1);
        cyc();
        chk("wr_c3_ack", req_ack, 4'b0001);
        chk("wr_c3_busy", busy, 1'b0);
        chk("wr_c3_resp", {rsp_rdata, rsp_resp}, 34'h0);
        req_valid[0] = 1'b0;
        slave_idle();
        cyc();
        chk("wr_after_idle", {busy, req_ack}, 5'b0);

        // read from requester 2 with a delayed arready
        set_req(2, 1, 32'h40, '0, '0);
        cyc();
        for (int d = 0; d < 5; d++) begin
            chk("rd_arvalid_wait", m_axi_arvalid, 1'b1);
            chk("rd_araddr_stable", m_axi_araddr, 32'h40);
            cyc();
        end
        m_axi_arready = 1;
        cyc();
        chk("rd_rready", {m_axi_rready, m_axi_arvalid}, 2'b10);
        m_axi_arready = 0; m_axi_rvalid = 1; m_axi_rdata = 32'h12345678; m_axi_rresp = 2'b10;
        cyc();
        chk("rd_ack", req_ack, 4'b0100);
        chk("rd_rdata", rsp_rdata, 32'h12345678);
        chk("rd_rresp", rsp_resp, 2'b10);
        slave_idle();
        req_valid[2] = 1'b0;
        cyc();

        // fairness: all four requesters held high from a fresh reset
        anrst_axi = 1'b0;
        cyc();
        anrst_axi = 1'b1;
        m_axi_awready = 1; m_axi_wready = 1; m_axi_bvalid = 1;
        for (int i = 0; i < N; i++) set_req(i, 0, 32'(i * 4), 32'(i), 4'hF);
        n_acks = 0;
        for (int t = 0; t < 60 && n_acks < 6; t++) begin
            cyc();
            for (int k = 0; k < N; k++)
                if (req_ack[k] && n_acks < 6) begin order[n_acks] = k; n_acks++; end
        end
        chk("rr_ack_count", 32'(n_acks), 32'd6);
        for (int k = 0; k < 6; k++) chk("rr_order", 32'(order[k]), 32'(k % 4));
        req_valid = '0;
        repeat (5) cyc();
        slave_idle();

        // write with wready three cycles ahead of awready
        m_axi_wready = 1;
        set_req(0, 0, 32'h20, 32'hCAFE0001, 4'h3);
        cyc();
        chk("split_c1", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
        for (int d = 0; d < 3; d++) begin
            cyc();
            chk("split_wait", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b100);
        end
        m_axi_awready = 1;
        cyc();
        chk("split_resp", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b001);
        m_axi_bvalid = 1;
        cyc();
        chk("split_ack", {req_ack, m_axi_bready}, 5'b00010);
        slave_idle();
        req_valid[0] = 1'b0;
        cyc();

        // requester 1 changes its inputs right after grant
        m_axi_awready = 1; m_axi_wready = 1; m_axi_bvalid = 1;
        set_req(1, 0, 32'h8, 32'h55AA55AA, 4'hF);
        cyc();
        chk("chg_awaddr", {m_axi_awvalid, m_axi_awaddr}, {1'b1, 32'h8});
        req_addr[1*AW +: AW] = 32'hC;
        req_valid[1] = 1'b0;
        got = 0;
        for (int t = 0; t < 10 && !got; t++) begin
            cyc();
            if (req_ack != '0) got = 1;
        end
        chk("chg_ack", {got, req_ack}, {1'b1, 4'b0010});
        slave_idle();
        cyc();

        // reset in the middle of a read, then a lone requester 3
        m_axi_arready = 1;
        set_req(0, 1, 32'h50, '0, '0);
        cyc();
        cyc();
        chk("rst_mid_rready", m_axi_rready, 1'b1);
        anrst_axi = 1'b0;
        #1;
        chk("rst_mid_drop", {m_axi_arvalid, m_axi_rready, busy, req_ack}, 7'b0);
        req_valid = '0;
        cyc();
        anrst_axi = 1'b1;
        set_req(3, 1, 32'h60, '0, '0);
        cyc();
        chk("rst_after_grant", {grant_id, m_axi_arvalid}, {2'd3, 1'b1});
        cyc();
        m_axi_arready = 0; m_axi_rvalid = 1; m_axi_rdata = 32'hA5A5A5A5;
        cyc();
        chk("rst_after_ack", req_ack, 4'b1000);
        slave_idle();
        req_valid = '0;
        cyc();

        // randomized traffic with occasional resets
        auto_slave = 1; auto_req = 1;
        for (int t = 0; t < 4000; t++) begin
            cyc();
            anrst_axi = ($urandom_range(0, 599) != 0);
        end
        auto_req = 0;
        anrst_axi = 1'b1;
        req_valid = '0;
        repeat (30) cyc();
        auto_slave = 0;
        slave_idle();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
